// File: rtl/ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame
//
// PS/2 device-to-host frame receiver. Synchronizes the raw keyboard clock and
// data pins, glitch-filters the clock, and deframes 11-bit frames
// (start=0, 8 data bits LSB first, odd parity, stop=1). Each good byte is
// presented on `data` with a one-cycle `data_en` strobe; a discarded frame
// (bad stop bit, bad parity when enabled, or mid-frame timeout) produces a
// one-cycle `frame_err` strobe and leaves `data` untouched.
//
// Optional feature macro: PS2_RX_PARITY_CHECK_EN
//   defined   -> odd parity over data+parity bit is enforced at STOP
//   undefined -> parity bit is captured but ignored
//
// Parameters:
//   FILTER_LEN      consecutive equal synchronized clock samples needed before
//                   the filtered clock changes level (2..255)
//   TIMEOUT_CYCLES  system clocks without a sample event, mid-frame, before
//                   the frame is abandoned
//
// Ports:
//   Clock      in   system clock
//   nReset     in   asynchronous active-low reset
//   PS2_CLK    in   raw keyboard clock pin (idles high)
//   PS2_DAT    in   raw keyboard data pin (idles high)
//   data       out  [7:0] last valid received byte
//   data_en    out  one-cycle strobe, data updated this cycle
//   frame_err  out  one-cycle strobe, frame discarded
// ---------------------------------------------------------------------------
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] data,
  output logic       data_en,
  output logic       frame_err
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
  localparam logic [7:0]      FILT_LAST = 8'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchronizers; both chains reset to the idle-high pin level.
  // -------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_s;
  logic       dat_s;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // -------------------------------------------------------------------------
  // Glitch filter: filt_cnt counts consecutive samples that disagree with the
  // current filtered level; any agreeing sample restarts the count, so only a
  // run of FILTER_LEN differing samples flips the filtered clock.
  // -------------------------------------------------------------------------
  logic [7:0] filt_cnt;
  logic       filt_clk;
  logic       filt_prev;
  logic       sample;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      filt_cnt  <= 8'd0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= 8'd0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s;
        filt_cnt <= 8'd0;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  // One-cycle event on the filtered 1->0 transition; PS2_DAT is sampled here.
  assign sample = filt_prev & ~filt_clk;

  // -------------------------------------------------------------------------
  // Deframing FSM
  // -------------------------------------------------------------------------
  state_t          state, state_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shift, shift_n;
  logic            par_q, par_n;
  logic [TO_W-1:0] to_cnt, to_n;
  logic [7:0]      data_n;
  logic            en_n;
  logic            err_n;
  logic            parity_ok;

`ifdef PS2_RX_PARITY_CHECK_EN
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign parity_ok = ^{shift, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
      par_q     <= 1'b0;
      to_cnt    <= '0;
      data      <= 8'd0;
      data_en   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      par_q     <= par_n;
      to_cnt    <= to_n;
      data      <= data_n;
      data_en   <= en_n;
      frame_err <= err_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par_q;
    to_n      = to_cnt;
    data_n    = data;
    en_n      = 1'b0;
    err_n     = 1'b0;

    if (sample) begin
      // A sample event always beats a coincident timeout expiry.
      to_n = '0;
      unique case (state)
        IDLE: begin
          if (!dat_s) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end
        end
        DATA: begin
          shift_n[bit_cnt] = dat_s;
          bit_cnt_n        = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = PARITY;
          end
        end
        PARITY: begin
          par_n   = dat_s;
          state_n = STOP;
        end
        STOP: begin
          if (dat_s && parity_ok) begin
            data_n = shift;
            en_n   = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (to_cnt == TO_LAST) begin
        state_n   = IDLE;
        err_n     = 1'b1;
        bit_cnt_n = 3'd0;
        to_n      = '0;
      end else begin
        to_n = to_cnt + TO_ONE;
      end
    end else begin
      to_n = '0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_frame
//
// Directed bench for ps2_rx_frame. Frames are bit-banged on PS2_CLK/PS2_DAT
// with a short PS/2 clock period and a reduced TIMEOUT_CYCLES so the run
// stays small. A per-cycle monitor (tick) counts data_en / frame_err pulses
// and records how many system clocks after the latest raw PS2_CLK fall they
// appear.
// ---------------------------------------------------------------------------
module tb_ps2_rx_frame;

  localparam int F = 8;    // FILTER_LEN
  localparam int T = 600;  // TIMEOUT_CYCLES
  localparam int H = 20;   // PS/2 half period in system clocks

  logic       Clock;
  logic       nReset;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] data;
  logic       data_en;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  int since_fall = 0;
  int en_cnt     = 0;
  int err_cnt    = 0;
  int en_lat     = 0;
  int err_lat    = 0;
  int both_cnt   = 0;
  int consec_cnt = 0;
  logic prev_pulse = 1'b0;

  logic [7:0] exp_data;

  ps2_rx_frame #(
    .FILTER_LEN     (F),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .data      (data),
    .data_en   (data_en),
    .frame_err (frame_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one system clock and sample outputs on the falling edge.
  task automatic tick();
    @(negedge Clock);
    since_fall++;
    if (data_en) begin
      en_cnt++;
      en_lat = since_fall;
    end
    if (frame_err) begin
      err_cnt++;
      err_lat = since_fall;
    end
    if (data_en && frame_err) both_cnt++;
    if ((data_en || frame_err) && prev_pulse) consec_cnt++;
    prev_pulse = data_en || frame_err;
  endtask

  task automatic clear_mon();
    en_cnt  = 0;
    err_cnt = 0;
    en_lat  = 0;
    err_lat = 0;
  endtask

  // Send the first nbits bits of a frame, then return pins to idle high.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int nbits);
    logic [10:0] fr;
    fr = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = fr[i];
      repeat (H) tick();
      PS2_CLK    = 1'b0;
      since_fall = 0;
      repeat (H) tick();
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    repeat (2 * H) tick();
  endtask

  initial begin
    int n;
    nReset  = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    repeat (3) tick();
    check("reset_data", 32'(data), 32'h00);
    check("reset_data_en", 32'(data_en), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    nReset = 1'b1;
    repeat (5) tick();

    // Valid 0x16 (parity 0, stop 1)
    clear_mon();
    send_frame(8'h16, 1'b0, 1'b1, 11);
    check("f16_en_cnt", 32'(en_cnt), 32'd1);
    check("f16_err_cnt", 32'(err_cnt), 32'd0);
    check("f16_data", 32'(data), 32'h16);
    check("f16_latency", 32'(en_lat), 32'(F + 3));

    // Back-to-back 0xF0 then 0x16
    clear_mon();
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    check("bb_f0_data", 32'(data), 32'hF0);
    send_frame(8'h16, 1'b0, 1'b1, 11);
    check("bb_en_cnt", 32'(en_cnt), 32'd2);
    check("bb_err_cnt", 32'(err_cnt), 32'd0);
    check("bb_16_data", 32'(data), 32'h16);

    // 0x5A with wrong parity bit (0)
    clear_mon();
    send_frame(8'h5A, 1'b0, 1'b1, 11);
`ifdef PS2_RX_PARITY_CHECK_EN
    exp_data = 8'h16;
    check("par_en_cnt", 32'(en_cnt), 32'd0);
    check("par_err_cnt", 32'(err_cnt), 32'd1);
`else
    exp_data = 8'h5A;
    check("par_en_cnt", 32'(en_cnt), 32'd1);
    check("par_err_cnt", 32'(err_cnt), 32'd0);
`endif
    check("par_data", 32'(data), 32'(exp_data));

    // 0x45 with bad stop bit, then a good 0x45
    clear_mon();
    send_frame(8'h45, 1'b0, 1'b0, 11);
    check("stop_en_cnt", 32'(en_cnt), 32'd0);
    check("stop_err_cnt", 32'(err_cnt), 32'd1);
    check("stop_data", 32'(data), 32'(exp_data));
    clear_mon();
    send_frame(8'h45, 1'b0, 1'b1, 11);
    check("f45_en_cnt", 32'(en_cnt), 32'd1);
    check("f45_data", 32'(data), 32'h45);

    // 3-cycle low glitch on PS2_CLK while idle
    clear_mon();
    PS2_CLK = 1'b0;
    repeat (3) tick();
    PS2_CLK = 1'b1;
    repeat (4 * H) tick();
    check("glitch_en_cnt", 32'(en_cnt), 32'd0);
    check("glitch_err_cnt", 32'(err_cnt), 32'd0);

    // Start + 4 data bits, then idle: timeout
    clear_mon();
    send_frame(8'h1E, 1'b1, 1'b1, 5);
    n = 0;
    while (err_cnt == 0 && n < T + F + 200) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check("to_err_cnt", 32'(err_cnt), 32'd1);
    check("to_latency", 32'(err_lat), 32'(F + 3 + T));
    check("to_en_cnt", 32'(en_cnt), 32'd0);
    check("to_data", 32'(data), 32'h45);
    clear_mon();
    send_frame(8'h1E, 1'b1, 1'b1, 11);
    check("f1e_en_cnt", 32'(en_cnt), 32'd1);
    check("f1e_err_cnt", 32'(err_cnt), 32'd0);
    check("f1e_data", 32'(data), 32'h1E);

    // Reset in the middle of 0x26 data bits
    clear_mon();
    send_frame(8'h26, 1'b0, 1'b1, 4);
    nReset = 1'b0;
    #1;
    check("rst_mid_data", 32'(data), 32'h00);
    check("rst_mid_data_en", 32'(data_en), 32'h0);
    check("rst_mid_frame_err", 32'(frame_err), 32'h0);
    repeat (3) tick();
    nReset = 1'b1;
    clear_mon();
    repeat (T + 50) tick();
    check("rst_idle_err_cnt", 32'(err_cnt), 32'd0);
    send_frame(8'h26, 1'b0, 1'b1, 11);
    check("f26_en_cnt", 32'(en_cnt), 32'd1);
    check("f26_err_cnt", 32'(err_cnt), 32'd0);
    check("f26_data", 32'(data), 32'h26);

    // Whole-run strobe properties
    check("never_both", 32'(both_cnt), 32'd0);
    check("never_consecutive", 32'(consec_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
